// File: rtl/gate_bist.sv
// Clocked BIST sequencer for a two-input gate: drives the four input vectors, samples the gate and tallies mismatches against TRUTH.
// Optional build macro GATE_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching sample.
module gate_bist #(
  parameter logic [3:0]  TRUTH  = 4'b1000,
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       gateOut,
  output logic       gateA,
  output logic       gateB,
  output logic       busy,
  output logic       done,
  output logic       allPassed,
  output logic [2:0] failCount,
  output logic [3:0] failMask
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] fail_count_q, fail_count_d;
  logic [3:0] fail_mask_q, fail_mask_d;
  logic       mismatch;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    fail_count_d = fail_count_q;
    fail_mask_d  = fail_mask_q;
    mismatch     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          idx_d        = 2'd0;
          cnt_d        = 4'd0;
          fail_count_d = 3'd0;
          fail_mask_d  = 4'd0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 4'd1;
        // The sample lands on the last edge of the hold window for this vector.
        if (cnt_q == SETTLE_C) begin
          mismatch = (gateOut != TRUTH[idx_q]);
          cnt_d    = 4'd0;
          idx_d    = idx_q + 2'd1;
          if (mismatch) begin
            fail_mask_d[idx_q] = 1'b1;
            fail_count_d       = fail_count_q + 3'd1;
          end
`ifdef GATE_BIST_STOP_ON_FAIL_EN
          if (mismatch || idx_q == 2'd3) state_d = DONE;
`else
          if (idx_q == 2'd3) state_d = DONE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gateA     = 1'b0;
    gateB     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    allPassed = 1'b0;
    failCount = fail_count_q;
    failMask  = fail_mask_q;
    case (state_q)
      RUN: begin
        busy  = 1'b1;
        gateA = idx_q[1];
        gateB = idx_q[0];
      end
      DONE: begin
        done      = 1'b1;
        allPassed = (fail_count_q == 3'd0);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= 4'd0;
      fail_count_q <= 3'd0;
      fail_mask_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      fail_count_q <= fail_count_d;
      fail_mask_q  <= fail_mask_d;
    end
  end

endmodule
